cci_mpf_fiu_responder: RTL and testbench

- FIU-end responder for the MPF CCI channel set, used as a simulation and loopback target under MPF shims.
- Accepts c0 read requests and c1 write requests from the AFU side.
- Backs them with a small line-addressed memory.
- Returns c0 read responses and c1 write acks, and drives almost-full flow control from request-queue occupancy.

---
 rtl/cci_mpf_fiu_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_cci_mpf_fiu_responder.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_fiu_responder.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_fiu_responder
// Purpose  : FIU-end responder for the MPF CCI channel set. It is a loopback
//            target that queues c0 reads and c1 writes in per-channel FIFOs.
//            Requests are served from a small line-addressed memory. It
//            returns c0 read data and c1 write acks, and it drives
//            almost-full from FIFO occupancy.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            c0_req_*              - read request (valid, addr, mdata)
//            c1_req_*              - write request (valid, addr, data, mdata)
//            c0_stall / c1_stall   - hold off dequeue per channel
//            c0_alm_full/c1_alm_full - request-queue almost full
//            c0_rsp_*              - read response (valid, data, mdata)
//            c1_rsp_*              - write ack (valid, mdata)
//            overflow_err          - sticky drop flags {c1, c0}
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_fiu_responder #(
    parameter int MEM_ADDR_BITS  = 6,
    parameter int REQ_DEPTH      = 16,
    parameter int ALM_FULL_SLACK = 8,
    parameter int RD_LATENCY     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    output logic         c0_alm_full,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [511:0] c1_req_data,
    input  logic [15:0]  c1_req_mdata,
    output logic         c1_alm_full,
    input  logic         c0_stall,
    input  logic         c1_stall,
    output logic         c0_rsp_valid,
    output logic [511:0] c0_rsp_data,
    output logic [15:0]  c0_rsp_mdata,
    output logic         c1_rsp_valid,
    output logic [15:0]  c1_rsp_mdata,
    output logic [1:0]   overflow_err
);

    localparam int c_ptr_w     = $clog2(REQ_DEPTH);
    localparam int c_cnt_w     = c_ptr_w + 1;
    localparam int c_mem_lines = 1 << MEM_ADDR_BITS;
    // The read pipeline has one stage fewer than the latency. The dequeue
    // cycle itself accounts for the remaining cycle.
    localparam int c_pipe_n    = RD_LATENCY - 1;

    localparam logic [c_cnt_w-1:0] c_full       = c_cnt_w'(REQ_DEPTH);
    localparam logic [c_cnt_w-1:0] c_alm_thresh = c_cnt_w'(REQ_DEPTH - ALM_FULL_SLACK);

    // Only the low address bits index the memory; the upper bits alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c0_req_addr[41:MEM_ADDR_BITS], c1_req_addr[41:MEM_ADDR_BITS]};

    // ------------------------------------------------------------------
    // Backing memory (never reset)
    // ------------------------------------------------------------------
    logic [511:0] mem_q [c_mem_lines];

    // ------------------------------------------------------------------
    // c0 request FIFO
    // ------------------------------------------------------------------
    logic [MEM_ADDR_BITS-1:0] c0_fifo_idx_q   [REQ_DEPTH];
    logic [15:0]              c0_fifo_mdata_q [REQ_DEPTH];
    logic [c_ptr_w-1:0]       c0_wr_ptr_q, c0_wr_ptr_d;
    logic [c_ptr_w-1:0]       c0_rd_ptr_q, c0_rd_ptr_d;
    logic [c_cnt_w-1:0]       c0_cnt_q, c0_cnt_d;
    logic                     c0_full, c0_enq, c0_deq;
    logic [MEM_ADDR_BITS-1:0] c0_head_idx;
    logic [15:0]              c0_head_mdata;

    always_comb begin
        c0_full       = (c0_cnt_q == c_full);
        c0_enq        = c0_req_valid && !c0_full;
        // Dequeue uses the registered count. As a result, an entry written
        // this cycle cannot leave before the next cycle.
        c0_deq        = (c0_cnt_q != '0) && !c0_stall && !reset;
        c0_head_idx   = c0_fifo_idx_q[c0_rd_ptr_q];
        c0_head_mdata = c0_fifo_mdata_q[c0_rd_ptr_q];
        c0_wr_ptr_d   = c0_wr_ptr_q + c_ptr_w'(c0_enq);
        c0_rd_ptr_d   = c0_rd_ptr_q + c_ptr_w'(c0_deq);
        c0_cnt_d      = c0_cnt_q + c_cnt_w'(c0_enq) - c_cnt_w'(c0_deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c0_wr_ptr_q <= '0;
            c0_rd_ptr_q <= '0;
            c0_cnt_q    <= '0;
        end else begin
            c0_wr_ptr_q <= c0_wr_ptr_d;
            c0_rd_ptr_q <= c0_rd_ptr_d;
            c0_cnt_q    <= c0_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (c0_enq) begin
            c0_fifo_idx_q[c0_wr_ptr_q]   <= c0_req_addr[MEM_ADDR_BITS-1:0];
            c0_fifo_mdata_q[c0_wr_ptr_q] <= c0_req_mdata;
        end
    end

    // ------------------------------------------------------------------
    // c1 request FIFO
    // ------------------------------------------------------------------
    logic [MEM_ADDR_BITS-1:0] c1_fifo_idx_q   [REQ_DEPTH];
    logic [511:0]             c1_fifo_data_q  [REQ_DEPTH];
    logic [15:0]              c1_fifo_mdata_q [REQ_DEPTH];
    logic [c_ptr_w-1:0]       c1_wr_ptr_q, c1_wr_ptr_d;
    logic [c_ptr_w-1:0]       c1_rd_ptr_q, c1_rd_ptr_d;
    logic [c_cnt_w-1:0]       c1_cnt_q, c1_cnt_d;
    logic                     c1_full, c1_enq, c1_deq;
    logic [MEM_ADDR_BITS-1:0] c1_head_idx;
    logic [511:0]             c1_head_data;
    logic [15:0]              c1_head_mdata;

    always_comb begin
        c1_full       = (c1_cnt_q == c_full);
        c1_enq        = c1_req_valid && !c1_full;
        c1_deq        = (c1_cnt_q != '0) && !c1_stall && !reset;
        c1_head_idx   = c1_fifo_idx_q[c1_rd_ptr_q];
        c1_head_data  = c1_fifo_data_q[c1_rd_ptr_q];
        c1_head_mdata = c1_fifo_mdata_q[c1_rd_ptr_q];
        c1_wr_ptr_d   = c1_wr_ptr_q + c_ptr_w'(c1_enq);
        c1_rd_ptr_d   = c1_rd_ptr_q + c_ptr_w'(c1_deq);
        c1_cnt_d      = c1_cnt_q + c_cnt_w'(c1_enq) - c_cnt_w'(c1_deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c1_wr_ptr_q <= '0;
            c1_rd_ptr_q <= '0;
            c1_cnt_q    <= '0;
        end else begin
            c1_wr_ptr_q <= c1_wr_ptr_d;
            c1_rd_ptr_q <= c1_rd_ptr_d;
            c1_cnt_q    <= c1_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (c1_enq) begin
            c1_fifo_idx_q[c1_wr_ptr_q]   <= c1_req_addr[MEM_ADDR_BITS-1:0];
            c1_fifo_data_q[c1_wr_ptr_q]  <= c1_req_data;
            c1_fifo_mdata_q[c1_wr_ptr_q] <= c1_req_mdata;
        end
    end

    // ------------------------------------------------------------------
    // c1 write: memory commits on the dequeue edge and the ack follows
    // one cycle later.
    // ------------------------------------------------------------------
    logic        c1_ack_vld_q, c1_ack_vld_d;
    logic [15:0] c1_ack_mdata_q, c1_ack_mdata_d;

    always_comb begin
        c1_ack_vld_d   = c1_deq;
        c1_ack_mdata_d = c1_head_mdata;
    end

    always_ff @(posedge clk) begin
        if (c1_deq) begin
            mem_q[c1_head_idx] <= c1_head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c1_ack_vld_q <= 1'b0;
        end else begin
            c1_ack_vld_q <= c1_ack_vld_d;
        end
        c1_ack_mdata_q <= c1_ack_mdata_d;
    end

    // ------------------------------------------------------------------
    // c0 read pipeline.
    // The memory read happens in the cycle after the dequeue, using the
    // registered index. A write dequeued in the same cycle as the read has
    // already committed by then, which gives write-first ordering without a
    // bypass. A write dequeued one cycle later commits only after the read,
    // so request order is preserved.
    // ------------------------------------------------------------------
    logic [c_pipe_n-1:0]      rd_vld_q, rd_vld_d;
    logic [15:0]              rd_mdata_q [c_pipe_n];
    logic [15:0]              rd_mdata_d [c_pipe_n];
    logic [MEM_ADDR_BITS-1:0] rd_idx_q, rd_idx_d;
    logic [511:0]             rd_mem_data;
    logic [511:0]             rd_out_data;

    always_comb begin
        rd_vld_d      = '0;
        rd_vld_d[0]   = c0_deq;
        rd_mdata_d[0] = c0_head_mdata;
        for (int i = 1; i < c_pipe_n; i++) begin
            rd_vld_d[i]   = rd_vld_q[i-1];
            rd_mdata_d[i] = rd_mdata_q[i-1];
        end
        rd_idx_d = c0_deq ? c0_head_idx : rd_idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
        rd_mdata_q <= rd_mdata_d;
        rd_idx_q   <= rd_idx_d;
    end

    assign rd_mem_data = mem_q[rd_idx_q];

    generate
        if (c_pipe_n >= 2) begin : g_rd_data_pipe
            logic [511:0] data_q [c_pipe_n-1];
            logic [511:0] data_d [c_pipe_n-1];

            always_comb begin
                data_d[0] = rd_mem_data;
                for (int i = 1; i < c_pipe_n - 1; i++) begin
                    data_d[i] = data_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                data_q <= data_d;
            end

            assign rd_out_data = data_q[c_pipe_n-2];
        end else begin : g_rd_data_direct
            assign rd_out_data = rd_mem_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky overflow: a request that arrives while the FIFO is full is
    // dropped. The check uses the registered count, so a dequeue in the
    // same cycle does not make room for it.
    // ------------------------------------------------------------------
    logic [1:0] overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | {c1_req_valid && c1_full, c0_req_valid && c0_full};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. They are forced to zero while reset is high, so nothing
    // undefined is visible before the first reset edge. Payloads read as
    // zero whenever the matching strobe is low.
    // ------------------------------------------------------------------
    assign c0_alm_full  = !reset && (c0_cnt_q >= c_alm_thresh);
    assign c1_alm_full  = !reset && (c1_cnt_q >= c_alm_thresh);
    assign c0_rsp_valid = !reset && rd_vld_q[c_pipe_n-1];
    assign c0_rsp_data  = c0_rsp_valid ? rd_out_data : '0;
    assign c0_rsp_mdata = c0_rsp_valid ? rd_mdata_q[c_pipe_n-1] : '0;
    assign c1_rsp_valid = !reset && c1_ack_vld_q;
    assign c1_rsp_mdata = c1_rsp_valid ? c1_ack_mdata_q : '0;
    assign overflow_err = reset ? 2'b00 : overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_fiu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_fiu_responder
// Purpose  : Directed self-checking bench for cci_mpf_fiu_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_fiu_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c0_alm_full;
    logic         c1_req_valid;
    logic [41:0]  c1_req_addr;
    logic [511:0] c1_req_data;
    logic [15:0]  c1_req_mdata;
    logic         c1_alm_full;
    logic         c0_stall;
    logic         c1_stall;
    logic         c0_rsp_valid;
    logic [511:0] c0_rsp_data;
    logic [15:0]  c0_rsp_mdata;
    logic         c1_rsp_valid;
    logic [15:0]  c1_rsp_mdata;
    logic [1:0]   overflow_err;

    int checks   = 0;
    int failures = 0;

    cci_mpf_fiu_responder #(
        .MEM_ADDR_BITS (6),
        .REQ_DEPTH     (16),
        .ALM_FULL_SLACK(8),
        .RD_LATENCY    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .c0_req_valid(c0_req_valid),
        .c0_req_addr (c0_req_addr),
        .c0_req_mdata(c0_req_mdata),
        .c0_alm_full (c0_alm_full),
        .c1_req_valid(c1_req_valid),
        .c1_req_addr (c1_req_addr),
        .c1_req_data (c1_req_data),
        .c1_req_mdata(c1_req_mdata),
        .c1_alm_full (c1_alm_full),
        .c0_stall    (c0_stall),
        .c1_stall    (c1_stall),
        .c0_rsp_valid(c0_rsp_valid),
        .c0_rsp_data (c0_rsp_data),
        .c0_rsp_mdata(c0_rsp_mdata),
        .c1_rsp_valid(c1_rsp_valid),
        .c1_rsp_mdata(c1_rsp_mdata),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c0_req_valid = 1'b0;
        c0_req_addr  = '0;
        c0_req_mdata = '0;
        c1_req_valid = 1'b0;
        c1_req_addr  = '0;
        c1_req_data  = '0;
        c1_req_mdata = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c0_req_valid = 1'($urandom_range(0, 1));
            c0_req_addr  = 42'({$urandom(), $urandom()});
            c0_req_mdata = 16'($urandom());
            c1_req_valid = 1'($urandom_range(0, 1));
            c1_req_addr  = 42'({$urandom(), $urandom()});
            for (int w = 0; w < 16; w++) c1_req_data[w*32 +: 32] = $urandom();
            c1_req_mdata = 16'($urandom());
            c0_stall     = 1'($urandom_range(0, 1));
            c1_stall     = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({c0_alm_full, c1_alm_full, c0_rsp_valid, c1_rsp_valid, overflow_err,
                 c0_rsp_mdata, c1_rsp_mdata} !== 38'd0) begin
                failures++;
                $display("FAIL reset_ctrl_outs cycle %0d: got %0h expected 0", i,
                         {c0_alm_full, c1_alm_full, c0_rsp_valid, c1_rsp_valid, overflow_err,
                          c0_rsp_mdata, c1_rsp_mdata});
            end
            checks++;
            if (c0_rsp_data !== 512'd0) begin
                failures++;
                $display("FAIL reset_rsp_data cycle %0d: got %0h expected 0", i, c0_rsp_data);
            end
            tick();
        end
        reset    = 1'b0;
        c0_stall = 1'b0;
        c1_stall = 1'b0;
        idle();
        #1;
        checks++;
        if ({c0_alm_full, c1_alm_full, c0_rsp_valid, c1_rsp_valid, overflow_err,
             c0_rsp_mdata, c1_rsp_mdata, c0_rsp_data} !== 550'd0) begin
            failures++;
            $display("FAIL reset_release_outs: got nonzero outputs, expected all 0");
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        logic [511:0] d;
        d = {16{32'hA5A5_0001}};
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'h5;
        c1_req_data  = d;
        c1_req_mdata = 16'h0011;
        tick(); idle();                         // t0+1
        checks++;
        if (c1_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_early: got %b expected 0", c1_rsp_valid);
        end
        tick();                                 // t0+2
        checks++;
        if (c1_rsp_valid !== 1'b1 || c1_rsp_mdata !== 16'h0011) begin
            failures++;
            $display("FAIL wr_ack: got valid=%b mdata=%h expected valid=1 mdata=0011",
                     c1_rsp_valid, c1_rsp_mdata);
        end
        tick();                                 // t0+3
        checks++;
        if (c1_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_single: got %b expected 0", c1_rsp_valid);
        end
        // read through an aliased address
        c0_req_valid = 1'b1;
        c0_req_addr  = 42'h45;
        c0_req_mdata = 16'h0022;
        tick(); idle();                         // t1+1
        tick();                                 // t1+2
        checks++;
        if (c0_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp_early: got %b expected 0", c0_rsp_valid);
        end
        tick();                                 // t1+3
        checks++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_mdata !== 16'h0022 || c0_rsp_data !== d) begin
            failures++;
            $display("FAIL rd_rsp: got valid=%b mdata=%h data=%h expected valid=1 mdata=0022 data=%h",
                     c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, d);
        end
        tick();
        checks++;
        if (c0_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp_single: got %b expected 0", c0_rsp_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hazard();
        logic [511:0] d0;
        logic [511:0] d1;
        d0 = {16{32'h0D0D_0000}};
        d1 = {16{32'hD1D1_1111}};
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'h7;
        c1_req_data  = d0;
        c1_req_mdata = 16'h0030;
        tick(); idle();
        tick();
        tick();
        // same-cycle write and read to line 7
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'h7;
        c1_req_data  = d1;
        c1_req_mdata = 16'h0031;
        c0_req_valid = 1'b1;
        c0_req_addr  = 42'h7;
        c0_req_mdata = 16'h0032;
        tick(); idle();                         // t+1
        tick();                                 // t+2
        checks++;
        if (c1_rsp_valid !== 1'b1 || c1_rsp_mdata !== 16'h0031) begin
            failures++;
            $display("FAIL hazard_ack: got valid=%b mdata=%h expected valid=1 mdata=0031",
                     c1_rsp_valid, c1_rsp_mdata);
        end
        tick();                                 // t+3
        checks++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_mdata !== 16'h0032 || c0_rsp_data !== d1) begin
            failures++;
            $display("FAIL hazard_rd: got valid=%b mdata=%h data=%h expected data=%h",
                     c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, d1);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_alm_full_overflow();
        logic [511:0] d;
        logic         exp_v;
        logic         exp_alm;
        d = {16{32'hA5A5_0001}};
        c0_stall = 1'b1;
        for (int k = 0; k < 17; k++) begin
            c0_req_valid = 1'b1;
            c0_req_addr  = 42'h5;
            c0_req_mdata = 16'(k);
            checks++;
            if (c0_alm_full !== (k >= 8)) begin
                failures++;
                $display("FAIL alm_rise cycle %0d: got %b expected %b", k, c0_alm_full, (k >= 8));
            end
            if (k == 16) begin
                checks++;
                if (overflow_err !== 2'b00) begin
                    failures++;
                    $display("FAIL ovf_early: got %b expected 00", overflow_err);
                end
            end
            tick();
        end
        idle();
        c0_stall = 1'b0;
        checks++;
        if (overflow_err !== 2'b01) begin
            failures++;
            $display("FAIL ovf_set: got %b expected 01", overflow_err);
        end
        for (int c = 17; c <= 36; c++) begin
            exp_alm = ((33 - c) >= 8);
            exp_v   = (c >= 19) && (c <= 34);
            checks++;
            if (c0_alm_full !== exp_alm) begin
                failures++;
                $display("FAIL alm_fall cycle %0d: got %b expected %b", c, c0_alm_full, exp_alm);
            end
            checks++;
            if (c0_rsp_valid !== exp_v) begin
                failures++;
                $display("FAIL drain_valid cycle %0d: got %b expected %b", c, c0_rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (c0_rsp_mdata !== 16'(c - 19) || c0_rsp_data !== d) begin
                    failures++;
                    $display("FAIL drain_rsp cycle %0d: got mdata=%h expected %h", c,
                             c0_rsp_mdata, 16'(c - 19));
                end
            end
            tick();
        end
        checks++;
        if (overflow_err !== 2'b01) begin
            failures++;
            $display("FAIL ovf_sticky: got %b expected 01", overflow_err);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        logic [511:0] dp;
        dp = {16{32'h1234_5678}};
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'h10;
        c1_req_data  = dp;
        c1_req_mdata = 16'h0040;
        tick(); idle();
        tick();
        tick();
        c1_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c1_req_valid = 1'b1;
            c1_req_addr  = 42'(16 + k);
            c1_req_data  = ~dp;
            c1_req_mdata = 16'(16'h0050 + k);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        c1_stall = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (c1_rsp_valid !== 1'b0 || c1_alm_full !== 1'b0 || overflow_err !== 2'b00) begin
                failures++;
                $display("FAIL midrst_quiet cycle %0d: got ack=%b alm=%b ovf=%b expected 0/0/00",
                         c, c1_rsp_valid, c1_alm_full, overflow_err);
            end
            tick();
        end
        // an empty FIFO gives the minimum two-cycle ack latency
        c1_req_valid = 1'b1;
        c1_req_addr  = 42'h20;
        c1_req_data  = dp;
        c1_req_mdata = 16'h0060;
        tick(); idle();
        checks++;
        if (c1_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ack_early: got %b expected 0", c1_rsp_valid);
        end
        tick();
        checks++;
        if (c1_rsp_valid !== 1'b1 || c1_rsp_mdata !== 16'h0060) begin
            failures++;
            $display("FAIL midrst_ack: got valid=%b mdata=%h expected valid=1 mdata=0060",
                     c1_rsp_valid, c1_rsp_mdata);
        end
        // committed lines survive reset; discarded writes never landed
        c0_req_valid = 1'b1;
        c0_req_addr  = 42'h10;
        c0_req_mdata = 16'h0070;
        tick();
        c0_req_addr  = 42'h05;
        c0_req_mdata = 16'h0071;
        tick(); idle();
        tick();
        checks++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_mdata !== 16'h0070 || c0_rsp_data !== dp) begin
            failures++;
            $display("FAIL midrst_rd10: got valid=%b mdata=%h data=%h expected data=%h",
                     c0_rsp_valid, c0_rsp_mdata, c0_rsp_data, dp);
        end
        tick();
        checks++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_mdata !== 16'h0071 ||
            c0_rsp_data !== {16{32'hA5A5_0001}}) begin
            failures++;
            $display("FAIL midrst_rd05: got valid=%b mdata=%h data=%h",
                     c0_rsp_valid, c0_rsp_mdata, c0_rsp_data);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        logic [511:0] exp_data [48];
        logic [15:0]  exp_m;
        int issued;
        int acked;
        int cyc;
        issued = 0;
        acked  = 0;
        cyc    = 0;
        while ((issued < 48 || acked < 48) && cyc < 2000) begin
            if (c1_rsp_valid === 1'b1) begin
                exp_m = 16'(16'h0100 + acked);
                checks++;
                if (c1_rsp_mdata !== exp_m) begin
                    failures++;
                    $display("FAIL wrap_ack %0d: got %h expected %h", acked, c1_rsp_mdata, exp_m);
                end
                acked++;
            end
            c1_stall = 1'($urandom_range(0, 1));
            if (issued < 48 && c1_alm_full === 1'b0) begin
                c1_req_valid = 1'b1;
                c1_req_addr  = {36'($urandom()), 6'(issued)};
                for (int w = 0; w < 16; w++) c1_req_data[w*32 +: 32] = $urandom();
                c1_req_mdata = 16'(16'h0100 + issued);
                exp_data[issued] = c1_req_data;
                issued++;
            end else begin
                c1_req_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        idle();
        c1_stall = 1'b0;
        checks++;
        if (acked !== 48) begin
            failures++;
            $display("FAIL wrap_ack_count: got %0d expected 48", acked);
        end
        tick();
        tick();
        // readback in the same order
        issued = 0;
        acked  = 0;
        cyc    = 0;
        while ((issued < 48 || acked < 48) && cyc < 2000) begin
            if (c0_rsp_valid === 1'b1) begin
                checks++;
                if (acked >= 48) begin
                    failures++;
                    $display("FAIL wrap_rd_extra: got extra response mdata=%h expected none", c0_rsp_mdata);
                end else if (c0_rsp_mdata !== 16'(16'h0200 + acked) || c0_rsp_data !== exp_data[acked]) begin
                    failures++;
                    $display("FAIL wrap_rd %0d: got mdata=%h data=%h expected mdata=%h data=%h",
                             acked, c0_rsp_mdata, c0_rsp_data, 16'(16'h0200 + acked), exp_data[acked]);
                end
                acked++;
            end
            c0_stall = 1'($urandom_range(0, 1));
            if (issued < 48 && c0_alm_full === 1'b0) begin
                c0_req_valid = 1'b1;
                c0_req_addr  = {36'($urandom()), 6'(issued)};
                c0_req_mdata = 16'(16'h0200 + issued);
                issued++;
            end else begin
                c0_req_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        idle();
        c0_stall = 1'b0;
        checks++;
        if (acked !== 48) begin
            failures++;
            $display("FAIL wrap_rd_count: got %0d expected 48", acked);
        end
        checks++;
        if (overflow_err !== 2'b00) begin
            failures++;
            $display("FAIL wrap_no_ovf: got %b expected 00", overflow_err);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset    = 1'b1;
        c0_stall = 1'b0;
        c1_stall = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_hazard();
        test_alm_full_overflow();
        test_mid_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
